// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: data width, canonical NOP encoding and the
// fetch FSM state type.
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

  // IDLE: nothing outstanding; WAIT: awaiting ack to keep;
  // DROP: awaiting ack whose data is thrown away after a redirect.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// Synchronous instruction FIFO with push/pop/flush and a combinational head.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_buf #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         data,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A push into a full buffer is only accepted when the head leaves the same cycle.
  assign do_push = push && (!full || do_pop);

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) begin
      mem[wr_ptr] <= data;
    end
  end

  // Pointer and occupancy tracking; flush empties the buffer in one edge.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requests feeding a small
// instruction buffer towards decode, with redirect/flush handling.
// Optional feature macro: FETCH_MISALIGN_CHK_EN (sticky misaligned-target flag
// that blocks fetching until an aligned redirect arrives).
module fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ins_dec_in,
  output logic [31:0] ins_pc,
  output logic        ins_valid,
  output logic        fetch_misalign
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e      state;
  fetch_state_e      state_nxt;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   req_pc;
  logic [XLEN-1:0]   tgt_pc;
  logic              can_issue;
  logic              push;
  logic              pop;
  logic              blocked;
  logic              buf_full;
  logic              buf_empty;
  logic [CW-1:0]     buf_count;
  logic [2*XLEN-1:0] buf_head;

  // Fetch addresses are always kept word aligned.
  assign tgt_pc = redirect_pc & ~XLEN'(3);

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_q;

  // Sticky flag: updated on every redirect from the target's low bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (redirect) begin
      misalign_q <= |redirect_pc[1:0];
    end
  end

  assign blocked        = misalign_q;
  assign fetch_misalign = misalign_q;
`else
  assign blocked        = 1'b0;
  assign fetch_misalign = 1'b0;
`endif

  // In IDLE nothing is outstanding, so occupancy is just the buffer count.
  // A redirect cycle never issues: the new PC only becomes valid at the edge.
  assign can_issue = !rst && !redirect && !blocked && (buf_count < CW'(BUF_DEPTH));

  assign pop = !buf_empty && !stall && !redirect;

  // Fetch FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, request and push decode.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (can_issue) begin
          imem_req  = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          state_nxt = IDLE;
          push      = !redirect && (!buf_full || pop);
        end else if (redirect) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (imem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Fetch PC and the PC of the request in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else if (redirect) begin
      pc <= tgt_pc;
    end else if (imem_req) begin
      req_pc <= pc;
      pc     <= pc + 32'd4;
    end
  end

  assign imem_addr = pc;

  fetch_buf #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (2 * XLEN)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .data  ({req_pc, imem_rdata}),
    .head  (buf_head),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

  assign ins_valid  = !buf_empty;
  assign ins_dec_in = buf_empty ? NOP_INSN : buf_head[XLEN-1:0];
  assign ins_pc     = buf_empty ? '0 : buf_head[2*XLEN-1:XLEN];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the driver keeps a transaction-level model
// of the fetch stream and pushes expectations; the monitor pops and compares.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int unsigned BUF_DEPTH = 2;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] ins_dec_in;
  logic [31:0] ins_pc;
  logic        ins_valid;
  logic        fetch_misalign;

  fetch_unit #(
    .RESET_PC  (RESET_PC),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .ins_dec_in     (ins_dec_in),
    .ins_pc         (ins_pc),
    .ins_valid      (ins_valid),
    .fetch_misalign (fetch_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_bad = 0;
  bit          mon_en = 0;

  // Reference model: program-order instruction stream and memory transaction.
  logic [63:0] ins_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] pc_m;
  bit          mis;
  bit          exp_req;
  bit          out_valid;
  bit          out_kill;
  logic [31:0] out_addr;
  int          out_cnt;
  int          ack_dly = 0;
  bit          win_on = 0;
  int          win_reqs = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model advances at the rising edge.
  task automatic step(input bit s, input bit r, input logic [31:0] rpc,
                      input bit frc_ack, input bit rs);
    bit ack_now;
    @(negedge clk);
    rst         = rs;
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    ack_now     = out_valid && (out_cnt == 0);
    imem_ack    = ack_now || frc_ack;
    if (ack_now) imem_rdata = (out_kill || r) ? 32'hDEAD_BEEF : mem_word(out_addr);
    else         imem_rdata = $urandom();
    exp_req = !rs && !out_valid && (ins_q.size() < BUF_DEPTH) && !r && !mis;
    if (exp_req) addr_q.push_back(pc_m);
    @(posedge clk);
    if (rs) begin
      ins_q.delete();
      addr_q.delete();
      pc_m      = RESET_PC;
      mis       = 0;
      out_valid = 0;
      out_kill  = 0;
    end else begin
      if (ack_now) begin
        out_valid = 0;
        if (!out_kill && !r) ins_q.push_back({out_addr, mem_word(out_addr)});
      end else if (out_valid) begin
        out_cnt--;
        if (r) out_kill = 1;
      end
      if (r) begin
        ins_q.delete();
        pc_m = rpc & ~32'h3;
`ifdef FETCH_MISALIGN_CHK_EN
        mis = (rpc[1:0] != 2'b00);
`else
        mis = 0;
`endif
      end
      if (exp_req) begin
        out_valid = 1;
        out_kill  = 0;
        out_addr  = pc_m;
        out_cnt   = (ack_dly < 0) ? int'($urandom_range(0, 2)) : ack_dly;
        pc_m      = pc_m + 32'd4;
      end
    end
  endtask

  // Run idle cycles until a request is in flight, either awaiting a later
  // ack (at_ack=0) or about to be acked this cycle (at_ack=1).
  task automatic seek(input bit at_ack);
    int unsigned n = 0;
    while (!(out_valid && ((out_cnt == 0) == at_ack)) && n < 20) begin
      step(0, 0, 32'h0, 0, 0);
      n++;
    end
    n_chk++;
    if (!(out_valid && ((out_cnt == 0) == at_ack))) begin
      n_bad++;
      $display("FAIL seek_timeout: got no request after %0d cycles expected one", n);
    end
  endtask

  // Monitor: compare DUT outputs against the scoreboard mid-cycle.
  always @(negedge clk) begin
    logic [63:0] h;
    logic [31:0] a;
    #2;
    if (mon_en && !rst) begin
      chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      if (exp_req && imem_req) begin
        if (addr_q.size() == 0) chk("addr_queue", 32'h0, 32'h1);
        else begin
          a = addr_q.pop_front();
          chk("imem_addr", imem_addr, a);
        end
      end else if (exp_req) begin
        void'(addr_q.pop_front());
      end
      if (win_on && imem_req) win_reqs++;
      chk("fetch_misalign", {31'b0, fetch_misalign}, {31'b0, mis});
      if (ins_q.size() != 0) begin
        h = ins_q[0];
        chk("ins_valid", {31'b0, ins_valid}, 32'h1);
        chk("ins_pc", ins_pc, h[63:32]);
        chk("ins_dec_in", ins_dec_in, h[31:0]);
        if (!stall && !redirect) void'(ins_q.pop_front());
      end else begin
        chk("ins_valid_empty", {31'b0, ins_valid}, 32'h0);
        chk("ins_dec_in_nop", ins_dec_in, NOP);
        chk("ins_pc_empty", ins_pc, 32'h0);
      end
    end
  end

  initial begin
    logic [31:0] rpc;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    pc_m = RESET_PC; mis = 0; exp_req = 0; out_valid = 0; out_kill = 0;
    out_addr = '0; out_cnt = 0;

    step(0, 0, 32'h0, 0, 1);
    step(0, 0, 32'h0, 0, 1);
    mon_en = 1;

    // Streaming with immediate acks and no stall.
    ack_dly = 0;
    repeat (20) step(0, 0, 32'h0, 0, 0);

    // Flush, then hold stall: the buffer fills and fetching stops.
    step(1, 1, 32'h40, 0, 0);
    win_reqs = 0;
    win_on   = 1;
    repeat (10) step(1, 0, 32'h0, 0, 0);
    win_on = 0;
    chk("stall_req_count", win_reqs, BUF_DEPTH);
    repeat (6) step(0, 0, 32'h0, 0, 0);

    // Redirect while a request is waiting; the late ack is discarded.
    ack_dly = 2;
    seek(0);
    step(0, 1, 32'h100, 0, 0);
    ack_dly = 0;
    repeat (8) step(0, 0, 32'h0, 0, 0);

    // Redirect in the same cycle as the ack.
    seek(1);
    step(0, 1, 32'h100, 0, 0);
    repeat (6) step(0, 0, 32'h0, 0, 0);

    // Misaligned target, then an aligned one.
    step(0, 1, 32'h102, 0, 0);
    repeat (5) step(0, 0, 32'h0, 0, 0);
    step(0, 1, 32'h200, 0, 0);
    repeat (6) step(0, 0, 32'h0, 0, 0);

    // Reset during WAIT followed by a stray ack.
    ack_dly = 1;
    seek(0);
    step(0, 0, 32'h0, 0, 1);
    ack_dly = 0;
    step(0, 0, 32'h0, 1, 0);
    repeat (6) step(0, 0, 32'h0, 0, 0);

    // Randomised traffic, including a target near the top of the address space.
    ack_dly = -1;
    for (int i = 0; i < 600; i++) begin
      rpc = $urandom();
      if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5, rpc, 0, 0);
    end
    step(0, 1, 32'h300, 0, 0);
    repeat (10) step(0, 0, 32'h0, 0, 0);

    mon_en = 0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter BUF_DEPTH, default 2, giving the instruction buffer entries; legal values are 2 and 4.
REQ-003 The block SHALL have one clock and a synchronous active-high reset, with ports as follows:
 clk  input  1  sole clock, rising edge
 rst  input  1  synchronous, active-high reset
 imem_req  output  1  fetch request valid
 imem_addr  output  32  fetch address, word aligned
 imem_ack  input  1  read data valid, one cycle per request
 imem_rdata  input  32  instruction word
 stall  input  1  decode cannot accept this cycle
 redirect  input  1  branch/jump target taken
 redirect_pc  input  32  new fetch address
 ins_dec_in  output  32  instruction to decode stage
 ins_pc  output  32  PC of ins_dec_in
 ins_valid  output  1  ins_dec_in holds a real instruction
 fetch_misalign  output  1  sticky misaligned-target flag

Function
REQ-004 The block SHALL hold a fetch PC that advances by 4 on each accepted request (imem_req high while the memory is free), wrapping modulo 2^32.
REQ-005 The block SHALL have at most one outstanding request; imem_req SHALL stay low from issue until imem_ack.
REQ-006 The block SHALL issue a request only if buffered entries plus outstanding requests is less than BUF_DEPTH.
REQ-007 The FSM SHALL have states IDLE (no request outstanding), WAIT (awaiting ack) and DROP (awaiting ack whose data is discarded).
REQ-008 Transitions: IDLE->WAIT on issue; WAIT->IDLE on imem_ack; WAIT->DROP on redirect without imem_ack; DROP->IDLE on imem_ack.
REQ-009 On imem_ack in WAIT, the block SHALL push {pc, imem_rdata} into the buffer in the same edge; a request MAY issue in that same cycle.
REQ-010 Buffer head SHALL drive ins_dec_in/ins_pc with ins_valid=1; the head SHALL pop on any cycle where ins_valid=1 and stall=0.
REQ-011 When the buffer is empty, the block SHALL drive ins_valid=0, ins_dec_in=32'h0000_0013 (NOP) and ins_pc=0.
REQ-012 On redirect, the block SHALL flush the buffer and load the fetch PC from redirect_pc at that edge; redirect SHALL override stall, push and pop.
REQ-013 If redirect coincides with imem_ack in WAIT, the block SHALL discard the returning data and go to IDLE.
REQ-014 Combined latency from a redirect with the memory idle and an immediate ack SHALL be: imem_req in the next cycle, then ins_valid on the cycle after the ack.
REQ-015 Simultaneous push and pop on a full buffer SHALL be legal and keep occupancy unchanged.

Reset
REQ-016 On rst at a rising edge, the block SHALL set fetch PC=RESET_PC, FSM=IDLE, buffer empty, imem_req=0, ins_valid=0, ins_dec_in=NOP, ins_pc=0 and fetch_misalign=0.
REQ-017 A rst asserted while in WAIT SHALL drop the pending response; an imem_ack in the first cycle after reset SHALL be ignored.

Configuration
REQ-018 With FETCH_MISALIGN_CHK_EN defined, a redirect with redirect_pc[1:0]!=0 SHALL set fetch_misalign and suppress requests until the next aligned redirect, which SHALL clear the flag.
REQ-019 Without FETCH_MISALIGN_CHK_EN, the block SHALL force redirect_pc[1:0] to 0 and tie fetch_misalign to 0.

Structure
REQ-020 The shared package rv32_pkg SHALL hold XLEN, the NOP encoding constant and the fetch FSM state enum.
REQ-021 The buffer SHALL be the sub-module fetch_buf, a synchronous FIFO with push/pop/flush inputs, full/empty/count outputs and a combinational head.

Verification
REQ-022 Reset, then ack every request after 1 cycle with stall=0 -> imem_addr sequence 0,4,8,... and ins_pc tracking with 1 fetch per 2 cycles.
REQ-023 Hold stall=1 for 10 cycles -> exactly BUF_DEPTH requests issued, then imem_req=0, and ins_dec_in stable.
REQ-024 Redirect to 32'h100 while in WAIT, then ack with 32'hDEADBEEF -> word discarded, next imem_addr=32'h100.
REQ-025 Redirect coincident with imem_ack -> ack data not delivered, and ins_valid=0 until the 32'h100 fetch returns.
REQ-026 With the macro defined, redirect to 32'h102 -> fetch_misalign=1 and no imem_req; redirect to 32'h200 -> flag clears and 32'h200 is fetched.
REQ-027 Assert rst during WAIT, then ack in the next cycle -> no push, and the first request after reset is at RESET_PC.
